// File: rtl/seq_add_pkg.sv
// Shared types and constants for the byte-serial adder controller.
// Holds the FSM state encoding and the width of the adder datapath slice.
package seq_add_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_add32_ctrl_rca8.sv
// 8-bit ripple-carry adder: the single narrow datapath slice shared by the
// serial controller. Carry ripples bit by bit from cin to cout.
module RCA_8
  import seq_add_pkg::*;
(
  input  logic [BYTE_W-1:0] A,
  input  logic [BYTE_W-1:0] B,
  input  logic              cin,
  output logic [BYTE_W-1:0] sum,
  output logic              cout
);

  logic [BYTE_W:0] c;

  // NOTE: every output of a combinational block is assigned on every pass
  // (c[0] first, then each bit in order), so no latch can be inferred.
  always_comb begin
    c[0] = cin;
    for (int i = 0; i < BYTE_W; i++) begin
      sum[i]   = A[i] ^ B[i] ^ c[i];
      c[i + 1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
    cout = c[BYTE_W];
  end

endmodule

// File: rtl/seq_add32_ctrl.sv
// Byte-serial wide adder: adds a + b + cin one byte per clock (LSB first)
// through one shared 8-bit ripple-carry adder, with a registered byte carry.
module seq_add32_ctrl
  import seq_add_pkg::*;
#(
  parameter int NUM_BYTES = 4
)
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [BYTE_W*NUM_BYTES-1:0] a,
  input  logic [BYTE_W*NUM_BYTES-1:0] b,
  input  logic                        cin,
  output logic                        busy,
  output logic                        done,
  output logic [BYTE_W*NUM_BYTES-1:0] sum,
  output logic                        cout
);

  localparam int W     = BYTE_W * NUM_BYTES;
  localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  state_t            state, state_nxt;
  logic [W-1:0]      a_reg, b_reg;
  logic              carry_reg;
  logic [IDX_W-1:0]  idx;
  logic              accept, last;
  logic [BYTE_W-1:0] a_byte, b_byte, add_sum;
  logic              add_cout;

  assign a_byte = a_reg[BYTE_W*idx +: BYTE_W];
  assign b_byte = b_reg[BYTE_W*idx +: BYTE_W];

  RCA_8 u_rca (
    .A    (a_byte),
    .B    (b_byte),
    .cin  (carry_reg),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Start is only honoured in IDLE or DONE; DONE accepting gives back-to-back.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = (idx == LAST_IDX);
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        accept    = start;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // busy/done are flops loaded from the next state so both outputs are
  // registered rather than decoded from the state vector.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == RUN);
      done  <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
    end else if (accept) begin
      a_reg     <= a;
      b_reg     <= b;
      carry_reg <= cin;
      idx       <= '0;
      sum       <= '0;
    end else if (state == RUN) begin
      sum[BYTE_W*idx +: BYTE_W] <= add_sum;
      carry_reg                 <= add_cout;
      // idx parks on the last byte; cout is only updated on that final step.
      if (last) cout <= add_cout;
      else      idx  <= idx + 1'b1;
    end
  end

endmodule
